// File: rtl/filter_valid_sched_if.sv
// filter_valid_sched_if: sample strobe, restart and warm-up status bundle.
// VALID_SCHED_STATS_EN adds the statistics counters to the bundle.
interface filter_valid_sched_if #(parameter int CntW = 8);
    logic en, flush, lb_ready, la_ready, out_valid, out_stb, out_first;
    logic [2:0] state;
    logic [CntW-1:0] warm_cnt;
`ifdef VALID_SCHED_STATS_EN
    logic [15:0] stat_out_cnt;
    logic [7:0] stat_flush_cnt;
    modport master(output en, flush, input lb_ready, la_ready, out_valid, out_stb, out_first, state, warm_cnt,
                   stat_out_cnt, stat_flush_cnt);
    modport slave(input en, flush, output lb_ready, la_ready, out_valid, out_stb, out_first, state, warm_cnt,
                  stat_out_cnt, stat_flush_cnt);
`else
    modport master(output en, flush, input lb_ready, la_ready, out_valid, out_stb, out_first, state, warm_cnt);
    modport slave(input en, flush, output lb_ready, la_ready, out_valid, out_stb, out_first, state, warm_cnt);
`endif
endinterface

// File: rtl/filter_valid_sched.sv
// filter_valid_sched: warm-up scheduler counting samples through lookback, lookahead and pipeline fill.
// Optional VALID_SCHED_STATS_EN adds saturating output-strobe and flush counters.
module filter_valid_sched #(
    parameter int DepthLB = 64,
    parameter int DepthLA = 64,
    parameter int PipeLat = 4
) (
    input logic validClk,
    input logic rst,
    filter_valid_sched_if.slave bus
);
    localparam int Total = DepthLB + DepthLA + PipeLat;
    localparam int CntW = $clog2(Total) + 1;
    localparam logic [CntW-1:0] ThLB = CntW'(DepthLB);
    localparam logic [CntW-1:0] ThLA = CntW'(DepthLB + DepthLA);
    localparam logic [CntW-1:0] ThT = CntW'(Total);
    typedef enum logic [2:0] {IDLE = 3'd0, FILL_LB = 3'd1, FILL_LA = 3'd2, PIPE = 3'd3, RUN = 3'd4} state_t;
    state_t st, nst;
    logic [CntW-1:0] cnt, nxt;
    logic lb, la, ov, first, cnt_en;
    assign nxt = cnt + CntW'(1);
    assign cnt_en = bus.en && st < RUN;
    // zero-length phases fall through because their thresholds coincide
    assign nst = nxt >= ThT ? RUN : nxt >= ThLA ? PIPE : nxt >= ThLB ? FILL_LA : FILL_LB;
    always_ff @(posedge validClk or negedge rst) begin
        if (!rst || bus.flush || st > RUN) begin
            st <= IDLE;
            cnt <= '0;
            lb <= 1'b0;
            la <= 1'b0;
            ov <= 1'b0;
            first <= 1'b0;
        end else begin
            first <= 1'b0;
            if (cnt_en) begin
                st <= nst;
                cnt <= nxt;
                lb <= nxt >= ThLB;
                la <= nxt >= ThLA;
                ov <= nxt >= ThT;
                first <= nxt == ThT;
            end
        end
    end
    assign bus.state = st;
    assign bus.warm_cnt = cnt;
    assign bus.lb_ready = lb;
    assign bus.la_ready = la;
    assign bus.out_valid = ov;
    assign bus.out_first = first;
    assign bus.out_stb = ov && bus.en;
`ifdef VALID_SCHED_STATS_EN
    logic [15:0] so;
    logic [7:0] sf;
    // statistics survive flush; only rst clears them
    always_ff @(posedge validClk or negedge rst) begin
        if (!rst) begin
            so <= '0;
            sf <= '0;
        end else begin
            if (ov && bus.en && so != 16'hFFFF) so <= so + 16'd1;
            if (bus.flush && st != IDLE && sf != 8'hFF) sf <= sf + 8'd1;
        end
    end
    assign bus.stat_out_cnt = so;
    assign bus.stat_flush_cnt = sf;
`endif
endmodule

// File: tb/tb_filter_valid_sched.sv
// tb_filter_valid_sched: two configurations (4/3/2 and 4/0/0) driven together and checked against a sample-count model.
module tb_filter_valid_sched;
    localparam int WA = $clog2(9) + 1;
    localparam int WB = $clog2(4) + 1;
    logic validClk = 1'b0, rst = 1'b1, en = 1'b0, flush = 1'b0;
    int tests = 0, fails = 0;
    int m[2], fst[2], so[2], sf[2];
    int thlb[2] = '{4, 4};
    int thla[2] = '{7, 4};
    int tot[2] = '{9, 4};
    filter_valid_sched_if #(.CntW(WA)) ifa();
    filter_valid_sched_if #(.CntW(WB)) ifb();
    assign ifa.en = en;
    assign ifa.flush = flush;
    assign ifb.en = en;
    assign ifb.flush = flush;
    filter_valid_sched #(.DepthLB(4), .DepthLA(3), .PipeLat(2)) dut_a(.validClk(validClk), .rst(rst), .bus(ifa));
    filter_valid_sched #(.DepthLB(4), .DepthLA(0), .PipeLat(0)) dut_b(.validClk(validClk), .rst(rst), .bus(ifb));
    always #5 validClk = ~validClk;

    task automatic chk(input string n, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    function automatic int exps(input int i);
        return m[i] == 0 ? 0 : m[i] >= tot[i] ? 4 : m[i] >= thla[i] ? 3 : m[i] >= thlb[i] ? 2 : 1;
    endfunction

    // model: number of accepted samples since reset/flush, everything else derived from it
    always @(posedge validClk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m[i] = 0; fst[i] = 0; so[i] = 0; sf[i] = 0;
            end else begin
                if (m[i] >= tot[i] && en && so[i] < 65535) so[i]++;
                if (flush && m[i] != 0 && sf[i] < 255) sf[i]++;
                fst[i] = 0;
                if (flush) m[i] = 0;
                else if (en && m[i] < tot[i]) begin
                    m[i]++;
                    fst[i] = m[i] == tot[i] ? 1 : 0;
                end
            end
        end
    end

    task automatic cmp(input int i, input int st, input int cnt, input int lb, input int la, input int ov,
                       input int stb, input int fs);
        chk($sformatf("m%0d_state", i), st, exps(i));
        chk($sformatf("m%0d_cnt", i), cnt, m[i]);
        chk($sformatf("m%0d_lb", i), lb, m[i] >= thlb[i] ? 1 : 0);
        chk($sformatf("m%0d_la", i), la, m[i] >= thla[i] ? 1 : 0);
        chk($sformatf("m%0d_ov", i), ov, m[i] >= tot[i] ? 1 : 0);
        chk($sformatf("m%0d_stb", i), stb, (m[i] >= tot[i] && en) ? 1 : 0);
        chk($sformatf("m%0d_first", i), fs, fst[i]);
    endtask

    always @(negedge validClk) begin
        cmp(0, ifa.state, ifa.warm_cnt, ifa.lb_ready, ifa.la_ready, ifa.out_valid, ifa.out_stb, ifa.out_first);
        cmp(1, ifb.state, ifb.warm_cnt, ifb.lb_ready, ifb.la_ready, ifb.out_valid, ifb.out_stb, ifb.out_first);
`ifdef VALID_SCHED_STATS_EN
        chk("m0_sout", ifa.stat_out_cnt, so[0]);
        chk("m0_sflush", ifa.stat_flush_cnt, sf[0]);
        chk("m1_sout", ifb.stat_out_cnt, so[1]);
        chk("m1_sflush", ifb.stat_flush_cnt, sf[1]);
`endif
    end

    task automatic cyc(input logic e, input logic f);
        en = e;
        flush = f;
        @(posedge validClk);
        #1;
    endtask

    task automatic scen1;
        for (int k = 1; k <= 9; k++) begin
            cyc(1, 0);
            if (k == 3) begin
                chk("s1_a_lb_k3", ifa.lb_ready, 0);
                chk("s1_b_state_k3", ifb.state, 1);
                chk("s1_b_ov_k3", ifb.out_valid, 0);
            end
            if (k == 4) begin
                chk("s1_a_lb_k4", ifa.lb_ready, 1);
                chk("s1_a_la_k4", ifa.la_ready, 0);
                chk("s1_b_lb_k4", ifb.lb_ready, 1);
                chk("s1_b_la_k4", ifb.la_ready, 1);
                chk("s1_b_ov_k4", ifb.out_valid, 1);
                chk("s1_b_state_k4", ifb.state, 4);
                chk("s1_b_first_k4", ifb.out_first, 1);
            end
            if (k == 7) begin
                chk("s1_a_la_k7", ifa.la_ready, 1);
                chk("s1_a_ov_k7", ifa.out_valid, 0);
                chk("s1_a_state_k7", ifa.state, 3);
            end
            if (k == 8) chk("s1_a_ov_k8", ifa.out_valid, 0);
        end
        chk("s1_a_ov_k9", ifa.out_valid, 1);
        chk("s1_a_first_k9", ifa.out_first, 1);
        chk("s1_a_state_k9", ifa.state, 4);
        chk("s1_a_cnt_k9", ifa.warm_cnt, 9);
        cyc(1, 0);
        chk("s1_a_first_drop", ifa.out_first, 0);
        repeat (4) cyc(1, 0);
        chk("s1_a_cnt_frozen", ifa.warm_cnt, 9);
        chk("s1_a_state_run", ifa.state, 4);
        chk("s1_b_cnt_frozen", ifb.warm_cnt, 4);
    endtask

    initial begin
        #1 rst = 1'b0;
        #2;
        chk("rst_a_state", ifa.state, 0);
        chk("rst_a_cnt", ifa.warm_cnt, 0);
        chk("rst_a_ov", ifa.out_valid, 0);
        chk("rst_a_stb", ifa.out_stb, 0);
        #9 rst = 1'b1;
        cyc(0, 0);
        chk("idle_a_state", ifa.state, 0);
        scen1();
        cyc(0, 1);
        for (int k = 0; k < 18; k++) begin
            cyc(k % 2 == 0, 0);
            if (k == 7) begin
                chk("s2_a_lb", ifa.lb_ready, 1);
                chk("s2_a_la_early", ifa.la_ready, 0);
            end
            if (k == 13) begin
                chk("s2_a_la", ifa.la_ready, 1);
                chk("s2_a_ov_early", ifa.out_valid, 0);
            end
        end
        chk("s2_a_ov", ifa.out_valid, 1);
        chk("s2_a_first_gone", ifa.out_first, 0);
        cyc(0, 1);
        repeat (5) cyc(1, 0);
        chk("s3_a_cnt5", ifa.warm_cnt, 5);
        cyc(1, 1);
        chk("s3_a_state", ifa.state, 0);
        chk("s3_a_cnt", ifa.warm_cnt, 0);
        chk("s3_a_lb", ifa.lb_ready, 0);
        chk("s3_b_state", ifb.state, 0);
        repeat (3) cyc(1, 1);
        chk("s3_hold_cnt", ifa.warm_cnt, 0);
        repeat (8) cyc(1, 0);
        chk("s3_a_ov8", ifa.out_valid, 0);
        chk("s3_a_cnt8", ifa.warm_cnt, 8);
        cyc(1, 0);
        chk("s3_a_ov9", ifa.out_valid, 1);
        cyc(0, 0);
        #2 rst = 1'b0;
        #1;
        chk("s4_a_ov", ifa.out_valid, 0);
        chk("s4_a_lb", ifa.lb_ready, 0);
        chk("s4_a_la", ifa.la_ready, 0);
        chk("s4_a_cnt", ifa.warm_cnt, 0);
        chk("s4_a_state", ifa.state, 0);
        chk("s4_b_ov", ifb.out_valid, 0);
        @(posedge validClk);
        #3 rst = 1'b1;
        scen1();
`ifdef VALID_SCHED_STATS_EN
        #1 rst = 1'b0;
        #2 rst = 1'b1;
        repeat (9) cyc(1, 0);
        cyc(0, 0);
        repeat (300) cyc(1, 0);
        cyc(0, 0);
        chk("s6_a_sout300", ifa.stat_out_cnt, 300);
        cyc(0, 1);
        cyc(0, 1);
        cyc(0, 0);
        chk("s6_a_sflush", ifa.stat_flush_cnt, 1);
        repeat (9) cyc(1, 0);
        repeat (70000) cyc(1, 0);
        cyc(0, 0);
        chk("s6_a_sout_sat", ifa.stat_out_cnt, 65535);
`endif
        cyc(0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/filter_valid_sched.md
Name: filter_valid_sched

Overview:
Warm-up scheduler for the batch estimation filter datapath.
- Counts input sample strobes through three fill phases: lookback buffer fill, lookahead buffer fill, and arithmetic pipeline flush.
- Raises per-phase ready flags that gate downstream accumulators and the output register.
- Supports synchronous restart (flush) without a global reset, and freezes its counter once in steady-state RUN.

Parameters:
DepthLB, 64, samples required to fill lookback buffer (>=1)
DepthLA, 64, samples required to fill lookahead buffer (>=0)
PipeLat, 4, samples required to flush arithmetic pipeline (>=0)
Total (localparam), DepthLB+DepthLA+PipeLat, samples to steady state
CntW (localparam), $clog2(Total)+1, counter width

Ports:
validClk  in   1     clock; all state updates on rising edge
rst       in   1     asynchronous, active-low reset
en        in   1     input sample strobe; one sample per high cycle
flush     in   1     synchronous restart of warm-up
lb_ready  out  1     lookback buffer holds DepthLB valid samples
la_ready  out  1     lookahead buffer holds DepthLA valid samples
out_valid out  1     filter output valid (level)
out_stb   out  1     out_valid & en (combinational)
out_first out  1     one-cycle pulse on first valid output
state     out  3     current FSM state encoding
warm_cnt  out  CntW  accepted-sample counter

Behaviour:
- Reset (rst=0, async): state=IDLE; warm_cnt=0; lb_ready, la_ready, out_valid, out_first all 0; out_stb=0.
- States: IDLE=0, FILL_LB=1, FILL_LA=2, PIPE=3, RUN=4. All other encodings go to IDLE on the next edge.
- IDLE -> FILL_LB on the first en=1 edge. That sample is counted, so warm_cnt=1.
- Counter:
  - Increments by 1 on each edge with en=1 and state!=RUN.
  - Never exceeds Total; frozen at Total in RUN.
  - No wrap-around is possible.
- Flag timing: all flags are registered and become 1 in the cycle after the edge on which warm_cnt reaches its threshold.
  - lb_ready: threshold DepthLB.
  - la_ready: threshold DepthLB+DepthLA.
  - out_valid: threshold Total.
- State transitions:
  - FILL_LB -> FILL_LA at DepthLB.
  - FILL_LA -> PIPE at DepthLB+DepthLA.
  - PIPE -> RUN at Total.
- Zero-length phases are skipped in the same edge, and their flags rise together with the previous phase's flag.
  - DepthLA=0: FILL_LB -> PIPE.
  - PipeLat=0: -> RUN directly.
- Flags are monotonic until flush or reset.
- out_first: 1 for exactly one cycle, the first cycle out_valid=1 after reset or flush.
- flush=1:
  - On the next edge: state=IDLE, warm_cnt=0, all flags 0.
  - flush has priority over en; a simultaneous sample is discarded, not counted.
  - flush held high keeps the block in IDLE.
- en=0 cycles: no state or counter change. Gaps are allowed in every phase.
- Reset asserted mid-operation: outputs go to reset values immediately, without waiting for a clock edge.

Optional Feature:
Macro VALID_SCHED_STATS_EN.
- Defined: adds the following outputs, both reset to 0 and cleared only by rst (not by flush):
  - stat_out_cnt [15:0]: saturating count of out_stb cycles.
  - stat_flush_cnt [7:0]: saturating count of edges with flush=1 while state!=IDLE.
- Not defined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. DepthLB=4, DepthLA=3, PipeLat=2; reset, then 9 consecutive en cycles.
   -> lb_ready=1 after the 4th edge; la_ready=1 after the 7th; out_valid=1 and out_first=1 after the 9th.
   -> out_first low one cycle later; warm_cnt stays 9 through 5 further en cycles; state=4.
2. Same parameters; en high on alternate cycles (18 cycles total).
   -> Thresholds are reached on the 4th/7th/9th en pulse only; no flag changes on en=0 cycles.
3. flush=1 together with en=1 at warm_cnt=5.
   -> Next cycle: state=0, warm_cnt=0, lb_ready=0. The sample is not counted; 9 fresh en pulses are required for out_valid.
4. Drop rst to 0 asynchronously mid-cycle while in RUN.
   -> out_valid, lb_ready, la_ready, warm_cnt reach 0 before the next edge.
   -> After release, behaviour matches scenario 1.
5. DepthLB=4, DepthLA=0, PipeLat=0; 4 en pulses.
   -> lb_ready, la_ready, out_valid rise in the same cycle; state goes 1 -> 4.
6. With VALID_SCHED_STATS_EN: scenario 1 followed by 300 en cycles in RUN, then 2 flushes.
   -> stat_out_cnt=300 (saturating test: 70000 cycles gives 65535); stat_flush_cnt=1 (second flush occurs in IDLE).
